// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//   Next-PC generator for the fetch stage. It holds the PC register and forms
//   the PC+4, pseudo-direct jump, PC-relative branch and register-jump targets.
//   It also provides a stall hold, a one-entry pending-redirect buffer and a
//   circular return-address stack (RAS).
// Ports
//   Clk, Reset      rising-edge clock, asynchronous active-high reset
//   Stall           hold the PC this cycle; a redirect is buffered instead
//   Jump/JumpImm    pseudo-direct jump request and its word index
//   Branch/Offset   taken-branch request and its signed word offset (from PC+4)
//   JumpReg/Target  register-jump request and its target
//   Link/Return     push PC+4 onto the RAS / take the target from the RAS top
//   PC, PCPlus4     current PC (registered) and PC+4 (combinational)
//   JumpAddress     {PCPlus4 upper bits, JumpImm, 2'b00}
//   RasEmpty/Full   RAS occupancy flags
//   RasUnderflow    registered one-cycle pulse: Return requested on an empty RAS
//   Pending         a redirect is buffered while stalled
module pc_redirect_unit #(
  parameter int                ADDR_W    = 32,
  parameter int                IMM_W     = 26,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                RAS_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Jump,
  input  logic [IMM_W-1:0]  JumpImm,
  input  logic              Branch,
  input  logic [15:0]       BranchOffset,
  input  logic              JumpReg,
  input  logic [ADDR_W-1:0] RegTarget,
  input  logic              Link,
  input  logic              Return,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PCPlus4,
  output logic [ADDR_W-1:0] JumpAddress,
  output logic              RasEmpty,
  output logic              RasFull,
  output logic              RasUnderflow,
  output logic              Pending
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              pend_q, pend_d;
  logic              unf_q, unf_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d, top_idx, wr_idx;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

  logic [ADDR_W-1:0] pc_plus4, jump_addr, branch_tgt, offset_ext, ras_top, redir_tgt;
  logic              ras_empty, ras_full, do_push, do_pop, ret_req, redirect, wr_en;

  assign pc_plus4   = pc_q + ADDR_W'(4);
  assign offset_ext = {{(ADDR_W-16){BranchOffset[15]}}, BranchOffset};
  assign branch_tgt = pc_plus4 + (offset_ext << 2);

  generate
    if (ADDR_W > IMM_W + 2) begin : g_ja_upper
      assign jump_addr = {pc_plus4[ADDR_W-1:IMM_W+2], JumpImm, 2'b00};
    end else begin : g_ja_full
      assign jump_addr = {JumpImm, 2'b00};
    end
  endgenerate

  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
  // ptr_q points at the next free slot, so the top lives one below it.
  assign top_idx   = ptr_q - PTR_W'(1);
  assign ras_top   = ras_q[top_idx];

  // RAS bookkeeping; acts in the request cycle even when stalled.
  always_comb begin
    do_push = Link & (Jump | JumpReg);
    ret_req = JumpReg & Return;
    do_pop  = ret_req & ~ras_empty;
    unf_d   = ret_req & ras_empty;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_en   = do_push;
    wr_idx  = ptr_q;
    if (do_push && do_pop) begin
      // Old top is read as the target, then replaced by the new return address.
      wr_idx = top_idx;
    end else if (do_push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (!ras_full) cnt_d = cnt_q + CNT_W'(1);
    end else if (do_pop) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Target select and stall/pending handling.
  always_comb begin
    redirect   = JumpReg | Jump | Branch;
    if (JumpReg)   redir_tgt = do_pop ? ras_top : RegTarget;
    else if (Jump) redir_tgt = jump_addr;
    else           redir_tgt = branch_tgt;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    if (!Stall) begin
      pend_d = 1'b0;
      if (redirect)    pc_d = redir_tgt;
      else if (pend_q) pc_d = pend_tgt_q;
      else             pc_d = pc_plus4;
    end else if (redirect) begin
      pend_d     = 1'b1;
      pend_tgt_d = redir_tgt;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      unf_q      <= 1'b0;
      ptr_q      <= '0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      unf_q      <= unf_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else if (wr_en) begin
      ras_q[wr_idx] <= pc_plus4;
    end
  end

  assign PC           = pc_q;
  assign PCPlus4      = pc_plus4;
  assign JumpAddress  = jump_addr;
  assign RasEmpty     = ras_empty;
  assign RasFull      = ras_full;
  assign RasUnderflow = unf_q;
  assign Pending      = pend_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic        Jump = 1'b0;
  logic [25:0] JumpImm = '0;
  logic        Branch = 1'b0;
  logic [15:0] BranchOffset = '0;
  logic        JumpReg = 1'b0;
  logic [31:0] RegTarget = '0;
  logic        Link = 1'b0;
  logic        Return = 1'b0;
  logic [31:0] PC, PCPlus4, JumpAddress;
  logic        RasEmpty, RasFull, RasUnderflow, Pending;

  pc_redirect_unit #(
    .ADDR_W(32), .IMM_W(26), .RESET_PC(32'h400), .RAS_DEPTH(4)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Jump(Jump), .JumpImm(JumpImm),
    .Branch(Branch), .BranchOffset(BranchOffset), .JumpReg(JumpReg),
    .RegTarget(RegTarget), .Link(Link), .Return(Return), .PC(PC),
    .PCPlus4(PCPlus4), .JumpAddress(JumpAddress), .RasEmpty(RasEmpty),
    .RasFull(RasFull), .RasUnderflow(RasUnderflow), .Pending(Pending)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic        pend, emp, full, unf;
    bit          flags_en;
    bit          ja_en;
    logic [31:0] ja;
  } exp_t;

  exp_t cq[$];  // expected state after the next rising edge
  exp_t zq[$];  // expected state right now (combinational / async)
  event chk_now;
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic check_entry(exp_t e);
    cmp({e.nm, ".PC"}, PC, e.pc);
    cmp({e.nm, ".PCPlus4"}, PCPlus4, e.pc + 32'd4);
    if (e.ja_en) cmp({e.nm, ".JumpAddress"}, JumpAddress, e.ja);
    if (e.flags_en) begin
      cmp({e.nm, ".Pending"}, {31'b0, Pending}, {31'b0, e.pend});
      cmp({e.nm, ".RasEmpty"}, {31'b0, RasEmpty}, {31'b0, e.emp});
      cmp({e.nm, ".RasFull"}, {31'b0, RasFull}, {31'b0, e.full});
      cmp({e.nm, ".RasUnderflow"}, {31'b0, RasUnderflow}, {31'b0, e.unf});
    end
  endtask

  // Monitors: one pops cycle expectations after each rising edge, the other
  // pops immediate expectations when the stimulus signals one.
  always begin
    @(posedge Clk);
    #1;
    if (cq.size() > 0) check_entry(cq.pop_front());
  end

  always begin
    @(chk_now);
    #1;
    if (zq.size() > 0) check_entry(zq.pop_front());
  end

  // Caller is at a falling edge with inputs driven; request pulses are cleared
  // at the next falling edge.
  task automatic step(string nm, logic [31:0] pc, bit pend, bit emp, bit full, bit unf);
    exp_t e;
    e = '{nm: nm, pc: pc, pend: pend, emp: emp, full: full, unf: unf,
          flags_en: 1'b1, ja_en: 1'b0, ja: 32'h0};
    cq.push_back(e);
    @(negedge Clk);
    Jump = 1'b0; Branch = 1'b0; JumpReg = 1'b0; Link = 1'b0; Return = 1'b0;
  endtask

  task automatic zchk(string nm, logic [31:0] pc, bit flags, bit ja_en, logic [31:0] ja,
                      bit pend, bit emp, bit full, bit unf);
    exp_t e;
    e = '{nm: nm, pc: pc, pend: pend, emp: emp, full: full, unf: unf,
          flags_en: flags, ja_en: ja_en, ja: ja};
    zq.push_back(e);
    -> chk_now;
  endtask

  initial begin
    @(negedge Clk);
    // Reset state and free-running increment
    zchk("reset", 32'h400, 1, 0, 0, 0, 1, 0, 0);
    Reset = 1'b0;
    step("idle1", 32'h404, 0, 1, 0, 0);
    step("idle2", 32'h408, 0, 1, 0, 0);
    step("idle3", 32'h40C, 0, 1, 0, 0);

    // Pseudo-direct jumps
    JumpReg = 1; RegTarget = 32'h0;
    step("jr_to_0", 32'h0, 0, 1, 0, 0);
    Jump = 1; JumpImm = 26'd3;
    zchk("ja_imm3", 32'h0, 0, 1, 32'h0000000C, 0, 1, 0, 0);
    step("jump_imm3", 32'h0000000C, 0, 1, 0, 0);
    JumpReg = 1; RegTarget = 32'hF000003C;
    step("jr_to_f03c", 32'hF000003C, 0, 1, 0, 0);
    Jump = 1; JumpImm = 26'd2;
    zchk("ja_upper", 32'hF000003C, 0, 1, 32'hF0000008, 0, 1, 0, 0);
    step("jump_upper", 32'hF0000008, 0, 1, 0, 0);

    // Branches and priority
    JumpReg = 1; RegTarget = 32'h100;
    step("jr_to_100", 32'h100, 0, 1, 0, 0);
    Branch = 1; BranchOffset = 16'hFFFE;
    step("branch_neg", 32'h0FC, 0, 1, 0, 0);
    Branch = 1; BranchOffset = 16'hFFFE; Jump = 1; JumpImm = 26'h40;
    step("jump_over_branch", 32'h100, 0, 1, 0, 0);
    Branch = 1; BranchOffset = 16'd3;
    step("branch_pos", 32'h110, 0, 1, 0, 0);
    Branch = 1; BranchOffset = 16'hFFFF; JumpReg = 1; RegTarget = 32'h77770;
    Jump = 1; JumpImm = 26'h5;
    step("jr_over_all", 32'h77770, 0, 1, 0, 0);
    JumpReg = 1; RegTarget = 32'h110;
    step("jr_to_110", 32'h110, 0, 1, 0, 0);

    // Stall with pending redirect, newest wins
    Stall = 1; Branch = 1; BranchOffset = 16'd4;
    step("stall_branch", 32'h110, 1, 1, 0, 0);
    Jump = 1; JumpImm = 26'd8;
    step("stall_jump", 32'h110, 1, 1, 0, 0);
    step("stall_idle", 32'h110, 1, 1, 0, 0);
    Stall = 0;
    step("pending_taken", 32'h020, 0, 1, 0, 0);
    // New redirect beats pending
    Stall = 1; Branch = 1; BranchOffset = 16'd0;
    step("stall_branch2", 32'h020, 1, 1, 0, 0);
    Stall = 0; Jump = 1; JumpImm = 26'h10;
    step("new_over_pending", 32'h040, 0, 1, 0, 0);
    step("pending_cleared", 32'h044, 0, 1, 0, 0);

    // Call/return via RAS with underflow
    JumpReg = 1; RegTarget = 32'h200;
    step("jr_to_200", 32'h200, 0, 1, 0, 0);
    Jump = 1; Link = 1; JumpImm = 26'h100;
    step("call1", 32'h400, 0, 0, 0, 0);
    JumpReg = 1; RegTarget = 32'h300;
    step("jr_to_300", 32'h300, 0, 0, 0, 0);
    Jump = 1; Link = 1; JumpImm = 26'h80;
    step("call2", 32'h200, 0, 0, 0, 0);
    JumpReg = 1; Return = 1; RegTarget = 32'hDEAD0;
    step("ret1", 32'h304, 0, 0, 0, 0);
    JumpReg = 1; Return = 1; RegTarget = 32'hDEAD0;
    step("ret2", 32'h204, 0, 1, 0, 0);
    JumpReg = 1; Return = 1; RegTarget = 32'h5550;
    step("ret_underflow", 32'h5550, 0, 1, 0, 1);
    step("underflow_gone", 32'h5554, 0, 1, 0, 0);

    // Overfill: oldest entry lost
    JumpReg = 1; Link = 1; RegTarget = 32'h1000;
    step("push1", 32'h1000, 0, 0, 0, 0);
    JumpReg = 1; Link = 1; RegTarget = 32'h2000;
    step("push2", 32'h2000, 0, 0, 0, 0);
    JumpReg = 1; Link = 1; RegTarget = 32'h3000;
    step("push3", 32'h3000, 0, 0, 0, 0);
    JumpReg = 1; Link = 1; RegTarget = 32'h4000;
    step("push4", 32'h4000, 0, 0, 1, 0);
    JumpReg = 1; Link = 1; RegTarget = 32'h5000;
    step("push5", 32'h5000, 0, 0, 1, 0);
    JumpReg = 1; Return = 1; RegTarget = 32'h9990;
    step("pop1", 32'h4004, 0, 0, 0, 0);
    JumpReg = 1; Return = 1; RegTarget = 32'h9990;
    step("pop2", 32'h3004, 0, 0, 0, 0);
    JumpReg = 1; Return = 1; RegTarget = 32'h9990;
    step("pop3", 32'h2004, 0, 0, 0, 0);
    JumpReg = 1; Return = 1; RegTarget = 32'h9990;
    step("pop4", 32'h1004, 0, 1, 0, 0);
    JumpReg = 1; Return = 1; RegTarget = 32'h9990;
    step("pop5_lost", 32'h9990, 0, 1, 0, 1);

    // Push and pop in the same cycle
    JumpReg = 1; Link = 1; RegTarget = 32'hA000;
    step("push_a", 32'hA000, 0, 0, 0, 0);
    JumpReg = 1; Link = 1; Return = 1; RegTarget = 32'hB000;
    step("push_pop", 32'h9994, 0, 0, 0, 0);
    JumpReg = 1; Return = 1; RegTarget = 32'hB000;
    step("pop_replaced", 32'hA004, 0, 1, 0, 0);

    // Reset while stalled with a pending redirect
    Stall = 1; Branch = 1; BranchOffset = 16'd0;
    step("stall_pend", 32'hA004, 1, 1, 0, 0);
    step("stall_hold", 32'hA004, 1, 1, 0, 0);
    Reset = 1;
    zchk("async_reset", 32'h400, 1, 0, 0, 0, 1, 0, 0);
    step("reset_held", 32'h400, 0, 1, 0, 0);
    Reset = 0; Stall = 0;
    step("after_reset", 32'h404, 0, 1, 0, 0);

    @(posedge Clk);
    #3;
    checks++;
    if (cq.size() != 0 || zq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expectations left, expected 0/0", cq.size(), zq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
